// File: rtl/ours_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ours_arb_pkg
//  Description : Shared types and helpers for the arbiter family.
//  Revision    : 1.0 - initial release
// ============================================================================
package ours_arb_pkg;

    // Arbiter FSM: free arbitration, first beat stalled, mid-packet lock
    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_HOLD = 2'd1,
        ST_PKT  = 2'd2
    } wrr_arb_st_t;

    // Index width that never collapses to zero bits for a single requester
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ours_rr_first_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ours_rr_first_pick
//  Description : Rotating first-one search. Returns the first asserted bit of
//                vec scanning start, start+1, ... with wrap modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module ours_rr_first_pick
    import ours_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = clog2_min1(N)
) (
    input  logic [N-1:0]    vec,
    input  logic [ID_W-1:0] start,
    output logic [N-1:0]    pick,
    output logic [ID_W-1:0] id,
    output logic            any
);

    // Bit j of the rotated vector is vec[(start + j) mod N]
    logic [N-1:0] w_rot;

    // Position start+j folded back into 0..N-1
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] s, input int j);
        int t;
        t = int'(s) + j;
        if (t >= N) begin
            t = t - N;
        end
        return ID_W'(t);
    endfunction

    // Rotate so the priority start lands on bit 0
    assign w_rot = N'({vec, vec} >> start);

    // Lowest set bit of the rotated vector, mapped back to a channel index
    always_comb begin
        id  = '0;
        any = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any && w_rot[j]) begin
                any = 1'b1;
                id  = wrap_add(start, j);
            end
        end
        pick = any ? (N'(1) << id) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/ours_vld_rdy_wrr_pkt_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ours_vld_rdy_wrr_pkt_arb
//  Description : Weighted round-robin valid/ready arbiter with packet locking,
//                grant hold under backpressure and integrated data/ID mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module ours_vld_rdy_wrr_pkt_arb
    import ours_arb_pkg::*;
#(
    parameter int  N_INPUT  = 4,
    parameter int  DATA_W   = 64,
    parameter int  WEIGHT_W = 4,
    localparam int ID_W     = clog2_min1(N_INPUT)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_INPUT-1:0]           in_vld,
    input  logic [N_INPUT-1:0]           in_last,
    input  logic [N_INPUT*DATA_W-1:0]    in_data,
    output logic [N_INPUT-1:0]           in_rdy,
    input  logic [N_INPUT*WEIGHT_W-1:0]  weight,
    output logic                         out_vld,
    output logic                         out_last,
    output logic [DATA_W-1:0]            out_data,
    output logic [ID_W-1:0]              out_id,
    input  logic                         out_rdy,
    output logic [N_INPUT-1:0]           grt
);

    localparam logic [ID_W-1:0]     c_last_init = ID_W'(N_INPUT - 1);
    localparam logic [ID_W-1:0]     c_one_id    = ID_W'(1);
    localparam logic [WEIGHT_W-1:0] c_one_w     = WEIGHT_W'(1);
    localparam logic [WEIGHT_W:0]   c_one_n     = {{WEIGHT_W{1'b0}}, 1'b1};

    wrr_arb_st_t          rff_state;
    wrr_arb_st_t          w_state_nxt;
    logic [ID_W-1:0]      rff_owner;
    logic [ID_W-1:0]      w_owner_nxt;
    logic [ID_W-1:0]      rff_last_id;
    logic [ID_W-1:0]      w_last_id_nxt;
    logic [WEIGHT_W-1:0]  rff_cnt;
    logic [WEIGHT_W-1:0]  w_cnt_nxt;

    logic [ID_W-1:0]      w_ps;
    logic [N_INPUT-1:0]   w_win_oh;
    logic [ID_W-1:0]      w_win_id;
    logic                 w_win_any;
    logic [N_INPUT-1:0]   w_owner_oh;
    logic                 w_owner_vld;
    logic                 w_beat;
    logic                 w_pkt_done;

    logic [ID_W-1:0]      w_cred_id;
    logic [WEIGHT_W-1:0]  w_weight_sel;
    logic [WEIGHT_W-1:0]  w_ew;
    logic [WEIGHT_W:0]    w_n;
    logic [WEIGHT_W-1:0]  w_cnt_upd;

    // Stay on the last winner while it still has credit, otherwise move past it
    assign w_ps = (rff_cnt != '0) ? rff_last_id
                : ((rff_last_id == c_last_init) ? '0 : rff_last_id + c_one_id);

    ours_rr_first_pick #(
        .N    (N_INPUT),
        .ID_W (ID_W)
    ) u_pick (
        .vec   (in_vld),
        .start (w_ps),
        .pick  (w_win_oh),
        .id    (w_win_id),
        .any   (w_win_any)
    );

    assign w_owner_oh  = N_INPUT'(1) << rff_owner;
    assign w_owner_vld = |(w_owner_oh & in_vld);

    // Credit bookkeeping for whichever channel would finish a packet this cycle
    always_comb begin
        w_cred_id    = (rff_state == ST_ARB) ? w_win_id : rff_owner;
        w_weight_sel = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            if (ID_W'(i) == w_cred_id) begin
                w_weight_sel = weight[i*WEIGHT_W +: WEIGHT_W];
            end
        end
        w_ew      = (w_weight_sel == '0) ? c_one_w : w_weight_sel;
        w_n       = ((w_cred_id == rff_last_id) ? {1'b0, rff_cnt} : '0) + c_one_n;
        w_cnt_upd = (w_n >= {1'b0, w_ew}) ? '0 : w_n[WEIGHT_W-1:0];
    end

    // Grant selection, handshake outputs and next-state decisions
    always_comb begin
        grt           = w_win_oh;
        out_id        = w_win_id;
        w_state_nxt   = rff_state;
        w_owner_nxt   = rff_owner;
        w_last_id_nxt = rff_last_id;
        w_cnt_nxt     = rff_cnt;

        case (rff_state)
            ST_HOLD, ST_PKT: begin
                grt    = w_owner_oh & in_vld;
                out_id = w_owner_vld ? rff_owner : '0;
            end
            default: begin
                grt    = w_win_oh;
                out_id = w_win_any ? w_win_id : '0;
            end
        endcase

        out_vld    = |grt;
        out_last   = |(grt & in_last);
        w_beat     = out_vld & out_rdy;
        w_pkt_done = w_beat & out_last;

        case (rff_state)
            ST_ARB: begin
                if (w_pkt_done) begin
                    w_last_id_nxt = w_cred_id;
                    w_cnt_nxt     = w_cnt_upd;
                end else if (w_beat) begin
                    w_owner_nxt = w_win_id;
                    w_state_nxt = ST_PKT;
                end else if (out_vld) begin
                    w_owner_nxt = w_win_id;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_pkt_done) begin
                    w_last_id_nxt = w_cred_id;
                    w_cnt_nxt     = w_cnt_upd;
                    w_state_nxt   = ST_ARB;
                end else if (w_beat) begin
                    w_state_nxt = ST_PKT;
                end else if (!w_owner_vld) begin
                    // Owner withdrew a stalled beat: release without charging credit
                    w_state_nxt = ST_ARB;
                end
            end
            ST_PKT: begin
                if (w_pkt_done) begin
                    w_last_id_nxt = w_cred_id;
                    w_cnt_nxt     = w_cnt_upd;
                    w_state_nxt   = ST_ARB;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    assign in_rdy = grt & {N_INPUT{out_rdy}};

    // AND-OR payload mux; zero when nothing is granted
    always_comb begin
        out_data = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            out_data = out_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grt[i]}});
        end
    end

    // FSM, lock owner and credit registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rff_state   <= ST_ARB;
            rff_owner   <= '0;
            rff_last_id <= c_last_init;
            rff_cnt     <= '0;
        end else begin
            rff_state   <= w_state_nxt;
            rff_owner   <= w_owner_nxt;
            rff_last_id <= w_last_id_nxt;
            rff_cnt     <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ours_vld_rdy_wrr_pkt_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ours_vld_rdy_wrr_pkt_arb
//  Description : Self-checking bench for the weighted packet arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ours_vld_rdy_wrr_pkt_arb;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int WW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    in_vld = '0;
    logic [N-1:0]    in_last = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_rdy;
    logic [N*WW-1:0] weight = {N{4'h1}};
    logic            out_vld;
    logic            out_last;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_rdy = 1'b1;
    logic [N-1:0]    grt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ours_vld_rdy_wrr_pkt_arb #(
        .N_INPUT  (N),
        .DATA_W   (DW),
        .WEIGHT_W (WW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (in_vld),
        .in_last  (in_last),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .weight   (weight),
        .out_vld  (out_vld),
        .out_last (out_last),
        .out_data (out_data),
        .out_id   (out_id),
        .out_rdy  (out_rdy),
        .grt      (grt)
    );

    // Reference model: m_mode 0 = free, 1 = first beat waiting, 2 = packet locked
    int m_mode  = 0;
    int m_owner = 0;
    int m_last  = N - 1;
    int m_cnt   = 0;

    function automatic int m_pick();
        int ps;
        ps = (m_cnt != 0) ? m_last : (m_last + 1) % N;
        for (int k = 0; k < N; k++) begin
            if (in_vld[(ps + k) % N]) return (ps + k) % N;
        end
        return -1;
    endfunction

    function automatic int m_granted();
        if (m_mode == 0) return m_pick();
        return in_vld[m_owner] ? m_owner : -1;
    endfunction

    function automatic int m_weight(input int o);
        int w;
        w = int'(weight[o*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic m_credit(input int o);
        int n;
        n = ((o == m_last) ? m_cnt : 0) + 1;
        m_last = o;
        m_cnt  = (n >= m_weight(o)) ? 0 : n;
    endtask

    always @(posedge clk) begin : ref_model
        int  g;
        bit  beat;
        bit  done;
        if (!rstn) begin
            m_mode = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
        end else begin
            g    = m_granted();
            beat = (g >= 0) && out_rdy;
            done = beat && in_last[g];
            case (m_mode)
                0: if (g >= 0) begin
                       if (done) m_credit(g);
                       else begin m_owner = g; m_mode = beat ? 2 : 1; end
                   end
                1: if (done) begin m_credit(m_owner); m_mode = 0; end
                   else if (beat) m_mode = 2;
                   else if (!in_vld[m_owner]) m_mode = 0;
                default: if (done) begin m_credit(m_owner); m_mode = 0; end
            endcase
        end
    end

    function automatic logic [DW-1:0] f_mux(input logic [N-1:0] g);
        logic [DW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) if (g[j]) r = in_data[j*DW +: DW];
        return r;
    endfunction

    function automatic logic [IW-1:0] f_idx(input logic [N-1:0] g);
        logic [IW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) if (g[j]) r = IW'(j);
        return r;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = {$urandom(), $urandom()};
    endtask

    // Leaves the bench at a falling edge with reset released and the DUT freshly reset
    task automatic do_reset(input logic [N*WW-1:0] w);
        @(negedge clk);
        rstn = 1'b0; in_vld = '0; in_last = '0; out_rdy = 1'b1; weight = w;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0; in_vld = '0; in_last = '0; out_rdy = 1'b1; weight = {N{4'h1}};
        rand_data();
        @(negedge clk);
        #1;
        checks++; if (grt !== 4'b0000) begin errors++; $display("FAIL reset_grt got %b exp 0000", grt); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id got %0d exp 0", out_id); end
        in_vld = 4'b1010;
        #1;
        checks++; if (grt !== 4'b0010) begin errors++; $display("FAIL reset_arb_grt got %b exp 0010", grt); end
        checks++; if (in_rdy !== 4'b0010) begin errors++; $display("FAIL reset_arb_rdy got %b exp 0010", in_rdy); end
        @(negedge clk);
        in_vld = '0;
        rstn = 1'b1;
    endtask

    task automatic test_rr_equal();
        int ids[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] eg;
        do_reset({N{4'h1}});
        in_vld = 4'hF; in_last = 4'hF; out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            #1;
            eg = N'(1) << ids[i];
            checks++; if (grt !== eg) begin errors++; $display("FAIL rr_grt[%0d] got %b exp %b", i, grt, eg); end
            checks++; if (out_id !== IW'(ids[i])) begin errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", i, out_id, ids[i]); end
            checks++; if (out_data !== f_mux(eg)) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, out_data, f_mux(eg)); end
            @(negedge clk);
        end
    endtask

    task automatic test_weights();
        int ids[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
        logic [N-1:0] eg;
        do_reset({4'd1, 4'd0, 4'd1, 4'd3});
        in_vld = 4'hF; in_last = 4'hF; out_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rand_data();
            #1;
            eg = N'(1) << ids[i];
            checks++; if (grt !== eg) begin errors++; $display("FAIL wrr_grt[%0d] got %b exp %b", i, grt, eg); end
            checks++; if (out_id !== IW'(ids[i])) begin errors++; $display("FAIL wrr_id[%0d] got %0d exp %0d", i, out_id, ids[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_packet_lock();
        logic [N-1:0] t_vld[7]  = '{4'b0001, 4'b0111, 4'b0111, 4'b0101, 4'b0111, 4'b0111, 4'b0101};
        logic [N-1:0] t_last[7] = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0101};
        // The bubble cycle shows no grant at all: the lock keeps ch0/ch2 out
        logic [N-1:0] t_g[7]    = '{4'b0001, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
        do_reset({N{4'h1}});
        out_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_vld = t_vld[i]; in_last = t_last[i];
            rand_data();
            #1;
            checks++; if (grt !== t_g[i]) begin errors++; $display("FAIL pkt_grt[%0d] got %b exp %b", i, grt, t_g[i]); end
            checks++; if (out_data !== f_mux(t_g[i])) begin errors++; $display("FAIL pkt_data[%0d] got %h exp %h", i, out_data, f_mux(t_g[i])); end
            checks++; if (out_last !== |(t_g[i] & t_last[i])) begin errors++; $display("FAIL pkt_last[%0d] got %b exp %b", i, out_last, |(t_g[i] & t_last[i])); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] t_vld[5] = '{4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
        logic         t_rdy[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [N-1:0] t_g[5]   = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        logic [DW-1:0] held;
        do_reset({N{4'h1}});
        in_last = 4'hF;
        rand_data();
        held = in_data[2*DW +: DW];
        for (int i = 0; i < 5; i++) begin
            in_vld = t_vld[i]; out_rdy = t_rdy[i];
            #1;
            checks++; if (grt !== t_g[i]) begin errors++; $display("FAIL bp_grt[%0d] got %b exp %b", i, grt, t_g[i]); end
            checks++; if (in_rdy !== (t_g[i] & {N{t_rdy[i]}})) begin errors++; $display("FAIL bp_rdy[%0d] got %b exp %b", i, in_rdy, t_g[i] & {N{t_rdy[i]}}); end
            if (i < 4) begin
                checks++; if (out_data !== held) begin errors++; $display("FAIL bp_data_stable[%0d] got %h exp %h", i, out_data, held); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap_hold_drop();
        logic [N*WW-1:0] t_w[8]   = '{16'h1111, 16'h1111, 16'h1111, 16'h1112,
                                      16'h1112, 16'h1112, 16'h1112, 16'h1112};
        logic [N-1:0]    t_vld[8] = '{4'b1000, 4'b1001, 4'b1000, 4'b0001,
                                      4'b0001, 4'b0000, 4'b1001, 4'b1001};
        logic            t_rdy[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [N-1:0]    t_g[8]   = '{4'b1000, 4'b0001, 4'b1000, 4'b0001,
                                      4'b0001, 4'b0000, 4'b0001, 4'b1000};
        do_reset({N{4'h1}});
        in_last = 4'hF;
        for (int i = 0; i < 8; i++) begin
            weight = t_w[i]; in_vld = t_vld[i]; out_rdy = t_rdy[i];
            rand_data();
            #1;
            checks++; if (grt !== t_g[i]) begin errors++; $display("FAIL wrap_grt[%0d] got %b exp %b", i, grt, t_g[i]); end
            checks++; if (out_id !== f_idx(t_g[i])) begin errors++; $display("FAIL wrap_id[%0d] got %0d exp %0d", i, out_id, f_idx(t_g[i])); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset({N{4'h1}});
        out_rdy = 1'b1; in_last = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            in_vld = 4'b0100;
            #1;
            checks++; if (grt !== 4'b0100) begin errors++; $display("FAIL rstpkt_lock[%0d] got %b exp 0100", i, grt); end
            @(negedge clk);
        end
        rstn = 1'b0; in_vld = 4'b0101;
        @(negedge clk);
        rstn = 1'b1; in_last = 4'b0101;
        #1;
        checks++; if (grt !== 4'b0001) begin errors++; $display("FAIL rstpkt_after got %b exp 0001", grt); end
        @(negedge clk);
        #1;
        checks++; if (grt !== 4'b0100) begin errors++; $display("FAIL rstpkt_next got %b exp 0100", grt); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int           g;
        logic [N-1:0] eg;
        do_reset({4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3))});
        for (int c = 0; c < 3000; c++) begin
            rstn = ($urandom_range(199) != 0);
            if (!rstn) weight = N*WW'({$urandom()});
            in_vld  = N'($urandom());
            in_last = N'($urandom());
            out_rdy = ($urandom_range(99) < 70);
            rand_data();
            #1;
            g  = m_granted();
            eg = (g >= 0) ? (N'(1) << g) : '0;
            checks++; if (grt !== eg) begin errors++; $display("FAIL rnd_grt[%0d] got %b exp %b", c, grt, eg); end
            checks++; if (out_vld !== (g >= 0)) begin errors++; $display("FAIL rnd_vld[%0d] got %b exp %b", c, out_vld, g >= 0); end
            checks++; if (out_id !== f_idx(eg)) begin errors++; $display("FAIL rnd_id[%0d] got %0d exp %0d", c, out_id, f_idx(eg)); end
            checks++; if (out_last !== |(eg & in_last)) begin errors++; $display("FAIL rnd_last[%0d] got %b exp %b", c, out_last, |(eg & in_last)); end
            checks++; if (out_data !== f_mux(eg)) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", c, out_data, f_mux(eg)); end
            checks++; if (in_rdy !== (eg & {N{out_rdy}})) begin errors++; $display("FAIL rnd_rdy[%0d] got %b exp %b", c, in_rdy, eg & {N{out_rdy}}); end
            @(negedge clk);
        end
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rr_equal();
        test_weights();
        test_packet_lock();
        test_backpressure();
        test_wrap_hold_drop();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
